cnu_layer_sequencer: RTL and testbench



---
 rtl/cnu_layer_sequencer_pkg.sv | 52 +++++
 rtl/cnu_layer_sequencer_step_counter.sv | 43 ++++
 rtl/cnu_layer_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_cnu_layer_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnu_layer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnu_layer_sequencer_pkg
// Description : Shared types, defaults and width helpers for the CNU layer
//               sequencer.
// Revision    : 1.0
// ============================================================================
package cnu_layer_sequencer_pkg;

    localparam int c_ROW_W    = 27;
    localparam int c_LAYERS   = 4;
    localparam int c_MAX_ITER = 10;
    localparam int c_RD_LAT   = 1;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_LOAD    = 4'd2,
        ST_TEMP    = 4'd3,
        ST_MIN     = 4'd4,
        ST_REFRESH = 4'd5,
        ST_SAT     = 4'd6,
        ST_RCOMP   = 4'd7,
        ST_QCOMP   = 4'd8,
        ST_WB      = 4'd9,
        ST_CHECK   = 4'd10,
        ST_DONE    = 4'd11
    } seq_state_e;

    typedef struct packed {
        logic mem_rd_en;
        logic mem_wr_en;
        logic load_to_mem;
        logic load_temp;
        logic en_minimun;
        logic refresh_min;
        logic en_saturation;
        logic en_r_compute;
        logic en_q_compute;
    } seq_strobe_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Dwell counter must hold the larger of ROW_W-1 and RD_LAT-1.
    function automatic int step_cnt_width(input int row_w, input int rd_lat);
        return $clog2(max2(row_w, rd_lat) + 1);
    endfunction

endpackage : cnu_layer_sequencer_pkg
`default_nettype wire

// File: rtl/cnu_layer_sequencer_step_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_step_counter
// Description : Loadable down-counter timing the FETCH and MIN dwell periods.
// Revision    : 1.0
// ============================================================================
module seq_step_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (i_dec && (r_count_q != '0)) begin
            w_count_d = r_count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;
    assign o_zero  = (r_count_q == '0);

endmodule : seq_step_counter
`default_nettype wire

// File: rtl/cnu_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cnu_layer_sequencer
// Description : Per-layer CNU strobe schedule, LLR memory strobes and
//               layer x iteration loop with syndrome-based early exit.
// Revision    : 1.0
// ============================================================================
module cnu_layer_sequencer
    import cnu_layer_sequencer_pkg::*;
#(
    parameter int ROW_W    = c_ROW_W,
    parameter int LAYERS   = c_LAYERS,
    parameter int MAX_ITER = c_MAX_ITER,
    parameter int RD_LAT   = c_RD_LAT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            syn_valid,
    input  logic                            syn_zero,
    output logic                            busy,
    output logic                            done,
    output logic                            success,
    output logic [$clog2(MAX_ITER+1)-1:0]   iter_cnt,
    output logic [$clog2(LAYERS)-1:0]       layer_idx,
    output logic                            mem_rd_en,
    output logic                            mem_wr_en,
    output logic                            load_to_mem,
    output logic                            load_temp,
    output logic                            en_minimun,
    output logic [4:0]                      count_minimun,
    output logic                            refresh_min,
    output logic                            en_saturation,
    output logic                            en_r_compute,
    output logic                            en_q_compute
);

    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int LW = $clog2(LAYERS);
    localparam int CW = step_cnt_width(ROW_W, RD_LAT);

    localparam logic [IW-1:0] c_ITER_LAST  = IW'(MAX_ITER - 1);
    localparam logic [LW-1:0] c_LAYER_LAST = LW'(LAYERS - 1);
    localparam logic [CW-1:0] c_FETCH_LOAD = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] c_MIN_LOAD   = CW'(ROW_W - 1);

    seq_state_e  r_state_q,   w_state_d;
    logic [IW-1:0] r_iter_q,  w_iter_d;
    logic [LW-1:0] r_layer_q, w_layer_d;
    logic        r_success_q, w_success_d;
    logic        r_busy_q,    w_busy_d;
    logic        r_done_q,    w_done_d;
    seq_strobe_t r_strb_q,    w_strb_d;

    logic          w_cnt_load;
    logic [CW-1:0] w_cnt_load_val;
    logic          w_cnt_dec;
    logic [CW-1:0] w_cnt;
    logic          w_cnt_zero;

    seq_step_counter #(
        .WIDTH (CW)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_iter_d       = r_iter_q;
        w_layer_d      = r_layer_q;
        w_success_d    = r_success_q;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = c_FETCH_LOAD;
        w_cnt_dec      = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_iter_d    = '0;
                    w_layer_d   = '0;
                    w_success_d = 1'b0;
                    w_state_d   = ST_FETCH;
                    w_cnt_load  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (w_cnt_zero) begin
                    w_state_d = ST_LOAD;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_LOAD:  w_state_d = ST_TEMP;
            ST_TEMP: begin
                w_state_d      = ST_MIN;
                w_cnt_load     = 1'b1;
                w_cnt_load_val = c_MIN_LOAD;
            end
            ST_MIN: begin
                if (w_cnt_zero) begin
                    w_state_d = ST_REFRESH;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_REFRESH: w_state_d = ST_SAT;
            ST_SAT:     w_state_d = ST_RCOMP;
            ST_RCOMP:   w_state_d = ST_QCOMP;
            ST_QCOMP:   w_state_d = ST_WB;
            ST_WB: begin
                if (r_layer_q != c_LAYER_LAST) begin
                    w_layer_d  = r_layer_q + LW'(1);
                    w_state_d  = ST_FETCH;
                    w_cnt_load = 1'b1;
                end else begin
                    w_state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (syn_valid) begin
                    if (syn_zero || (r_iter_q == c_ITER_LAST)) begin
                        w_success_d = syn_zero;
                        w_state_d   = ST_DONE;
                    end else begin
                        w_iter_d   = r_iter_q + IW'(1);
                        w_layer_d  = '0;
                        w_state_d  = ST_FETCH;
                        w_cnt_load = 1'b1;
                    end
                end
            end
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        w_strb_d               = '0;
        w_strb_d.mem_rd_en     = (w_state_d == ST_FETCH) && (r_state_q != ST_FETCH);
        w_strb_d.mem_wr_en     = (w_state_d == ST_WB);
        w_strb_d.load_to_mem   = (w_state_d == ST_LOAD);
        w_strb_d.load_temp     = (w_state_d == ST_TEMP);
        w_strb_d.en_minimun    = (w_state_d == ST_MIN);
        w_strb_d.refresh_min   = (w_state_d == ST_REFRESH);
        w_strb_d.en_saturation = (w_state_d == ST_SAT);
        w_strb_d.en_r_compute  = (w_state_d == ST_RCOMP);
        w_strb_d.en_q_compute  = (w_state_d == ST_QCOMP);
        w_busy_d               = (w_state_d != ST_IDLE);
        w_done_d               = (w_state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_iter_q    <= '0;
            r_layer_q   <= '0;
            r_success_q <= 1'b0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_strb_q    <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_iter_q    <= w_iter_d;
            r_layer_q   <= w_layer_d;
            r_success_q <= w_success_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_strb_q    <= w_strb_d;
        end
    end

    assign busy          = r_busy_q;
    assign done          = r_done_q;
    assign success       = r_success_q;
    assign iter_cnt      = r_iter_q;
    assign layer_idx     = r_layer_q;
    assign mem_rd_en     = r_strb_q.mem_rd_en;
    assign mem_wr_en     = r_strb_q.mem_wr_en;
    assign load_to_mem   = r_strb_q.load_to_mem;
    assign load_temp     = r_strb_q.load_temp;
    assign en_minimun    = r_strb_q.en_minimun;
    assign refresh_min   = r_strb_q.refresh_min;
    assign en_saturation = r_strb_q.en_saturation;
    assign en_r_compute  = r_strb_q.en_r_compute;
    assign en_q_compute  = r_strb_q.en_q_compute;

    // Search index counts up while the dwell counter counts down.
    assign count_minimun = (r_state_q == ST_MIN) ? 5'(c_MIN_LOAD - w_cnt) : 5'd0;

endmodule : cnu_layer_sequencer
`default_nettype wire

// File: tb/tb_cnu_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnu_layer_sequencer
// Description : Directed self-checking bench; default, MAX_ITER=3 and
//               RD_LAT=3 instances share one stimulus set.
// Revision    : 1.0
// ============================================================================
module tb_cnu_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, syn_valid, syn_zero;

    // Default instance
    logic       a_busy, a_done, a_success, a_rd, a_wr, a_ld, a_tmp, a_min, a_ref, a_sat, a_rc, a_qc;
    logic [3:0] a_iter;
    logic [1:0] a_layer;
    logic [4:0] a_cmin;
    // MAX_ITER = 3 instance
    logic       b_busy, b_done, b_success, b_rd, b_wr, b_ld, b_tmp, b_min, b_ref, b_sat, b_rc, b_qc;
    logic [1:0] b_iter;
    logic [1:0] b_layer;
    logic [4:0] b_cmin;
    // RD_LAT = 3 instance
    logic       c_busy, c_done, c_success, c_rd, c_wr, c_ld, c_tmp, c_min, c_ref, c_sat, c_rc, c_qc;
    logic [3:0] c_iter;
    logic [1:0] c_layer;
    logic [4:0] c_cmin;

    cnu_layer_sequencer u_dut_a (
        .clk(clk), .rst(rst), .start(start), .syn_valid(syn_valid), .syn_zero(syn_zero),
        .busy(a_busy), .done(a_done), .success(a_success), .iter_cnt(a_iter), .layer_idx(a_layer),
        .mem_rd_en(a_rd), .mem_wr_en(a_wr), .load_to_mem(a_ld), .load_temp(a_tmp),
        .en_minimun(a_min), .count_minimun(a_cmin), .refresh_min(a_ref),
        .en_saturation(a_sat), .en_r_compute(a_rc), .en_q_compute(a_qc)
    );

    cnu_layer_sequencer #(.MAX_ITER(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .syn_valid(syn_valid), .syn_zero(syn_zero),
        .busy(b_busy), .done(b_done), .success(b_success), .iter_cnt(b_iter), .layer_idx(b_layer),
        .mem_rd_en(b_rd), .mem_wr_en(b_wr), .load_to_mem(b_ld), .load_temp(b_tmp),
        .en_minimun(b_min), .count_minimun(b_cmin), .refresh_min(b_ref),
        .en_saturation(b_sat), .en_r_compute(b_rc), .en_q_compute(b_qc)
    );

    cnu_layer_sequencer #(.RD_LAT(3)) u_dut_c (
        .clk(clk), .rst(rst), .start(start), .syn_valid(syn_valid), .syn_zero(syn_zero),
        .busy(c_busy), .done(c_done), .success(c_success), .iter_cnt(c_iter), .layer_idx(c_layer),
        .mem_rd_en(c_rd), .mem_wr_en(c_wr), .load_to_mem(c_ld), .load_temp(c_tmp),
        .en_minimun(c_min), .count_minimun(c_cmin), .refresh_min(c_ref),
        .en_saturation(c_sat), .en_r_compute(c_rc), .en_q_compute(c_qc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int onehot_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if ($countones({a_rd, a_wr, a_ld, a_tmp, a_min, a_ref, a_sat, a_rc, a_qc}) > 1) onehot_bad++;
        if ($countones({b_rd, b_wr, b_ld, b_tmp, b_min, b_ref, b_sat, b_rc, b_qc}) > 1) onehot_bad++;
        if ($countones({c_rd, c_wr, c_ld, c_tmp, c_min, c_ref, c_sat, c_rc, c_qc}) > 1) onehot_bad++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; syn_valid = 1'b0; syn_zero = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int a_strobes();
        return $countones({a_rd, a_wr, a_ld, a_tmp, a_min, a_ref, a_sat, a_rc, a_qc});
    endfunction

    initial begin
        int rd_cyc[4];
        int ld_cyc[4];
        int n_rd, n_ld, q_first, wr_first, done_cyc, done_cnt, n_wr, iter_done;
        int cm4, cm17, cm30, cm31, lay106, lay141, busy142, busy143, succ_done, idle_act;

        rst = 1'b1; start = 1'b0; syn_valid = 1'b0; syn_zero = 1'b0;

        // ---------------- Reset in the middle of MIN ----------------
        do_reset();
        start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_cmin", 32'(a_cmin), 32'd12);
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_outputs", {a_busy, a_done, a_success, a_iter, a_layer, a_cmin, 9'(a_strobes())}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", {a_busy, a_done, a_success, a_iter, a_layer, a_cmin, 9'(a_strobes())}, 32'd0);
        idle_act = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            idle_act += a_strobes() + int'(a_busy);
        end
        chk("idle_no_strobe", 32'(idle_act), 32'd0);

        // ---------------- Single-iteration pass ----------------
        do_reset();
        start = 1'b1; syn_valid = 1'b1; syn_zero = 1'b1;
        n_rd = 0; n_ld = 0; q_first = -1; wr_first = -1; done_cyc = -1; done_cnt = 0;
        iter_done = -1; succ_done = -1;
        cm4 = -1; cm17 = -1; cm30 = -1; cm31 = -1; lay106 = -1; lay141 = -1; busy142 = -1; busy143 = -1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (a_rd) begin
                if (n_rd < 4) rd_cyc[n_rd] = k;
                n_rd++;
            end
            if (a_ld) begin
                if (n_ld < 4) ld_cyc[n_ld] = k;
                n_ld++;
            end
            if (a_qc && q_first < 0) q_first = k;
            if (a_wr && wr_first < 0) wr_first = k;
            if (a_done) begin
                done_cnt++; done_cyc = k; iter_done = int'(a_iter); succ_done = int'(a_success);
            end
            case (k)
                4:   cm4 = int'(a_cmin);
                17:  cm17 = int'(a_cmin);
                30:  cm30 = int'(a_cmin);
                31:  cm31 = int'(a_cmin);
                106: lay106 = int'(a_layer);
                141: lay141 = int'(a_layer);
                142: busy142 = int'(a_busy);
                143: busy143 = int'(a_busy);
                default: ;
            endcase
        end
        chk("rd_count", 32'(n_rd), 32'd4);
        chk("rd_0", 32'(rd_cyc[0]), 32'd1);
        chk("rd_1", 32'(rd_cyc[1]), 32'd36);
        chk("rd_2", 32'(rd_cyc[2]), 32'd71);
        chk("rd_3", 32'(rd_cyc[3]), 32'd106);
        chk("ld_0", 32'(ld_cyc[0]), 32'd2);
        chk("ld_1", 32'(ld_cyc[1]), 32'd37);
        chk("ld_2", 32'(ld_cyc[2]), 32'd72);
        chk("ld_3", 32'(ld_cyc[3]), 32'd107);
        chk("cmin_c4", 32'(cm4), 32'd0);
        chk("cmin_c17", 32'(cm17), 32'd13);
        chk("cmin_c30", 32'(cm30), 32'd26);
        chk("cmin_c31", 32'(cm31), 32'd0);
        chk("qcomp_first", 32'(q_first), 32'd34);
        chk("wr_first", 32'(wr_first), 32'd35);
        chk("layer_c106", 32'(lay106), 32'd3);
        chk("layer_check", 32'(lay141), 32'd3);
        chk("done_cycle", 32'(done_cyc), 32'd142);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("done_success", 32'(succ_done), 32'd1);
        chk("done_iter", 32'(iter_done), 32'd0);
        chk("busy_at_done", 32'(busy142), 32'd1);
        chk("busy_after", 32'(busy143), 32'd0);

        // ---------------- Iteration cap (MAX_ITER=3), starts ignored while busy ----------------
        do_reset();
        start = 1'b1; syn_valid = 1'b1; syn_zero = 1'b0;
        n_wr = 0; done_cyc = -1; iter_done = -1; succ_done = -1;
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk);
            start = ((k % 50) == 0) && (k < 400);
            if (b_wr && done_cyc < 0) n_wr++;
            if (b_done) begin
                done_cyc = k; iter_done = int'(b_iter); succ_done = int'(b_success);
            end
        end
        chk("cap_done_cycle", 32'(done_cyc), 32'd424);
        chk("cap_wr_pulses", 32'(n_wr), 32'd12);
        chk("cap_success", 32'(succ_done), 32'd0);
        chk("cap_iter", 32'(iter_done), 32'd2);

        // ---------------- Early exit, CHECK stalls for syn_valid ----------------
        do_reset();
        start = 1'b1; syn_valid = 1'b1; syn_zero = 1'b0;
        n_wr = 0; done_cyc = -1; iter_done = -1; succ_done = -1;
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (a_wr && done_cyc < 0) n_wr++;
            if (a_done) begin
                done_cyc = k; iter_done = int'(a_iter); succ_done = int'(a_success);
            end
            if (k == 145) begin
                chk("check_wait_busy", 32'(a_busy), 32'd1);
                chk("check_wait_quiet", 32'(a_strobes()), 32'd0);
                chk("check_wait_iter", 32'(a_iter), 32'd0);
            end
            if (k == 310) begin
                chk("held_iter", 32'(a_iter), 32'd1);
                chk("held_success", 32'(a_success), 32'd1);
                chk("held_layer", 32'(a_layer), 32'd3);
            end
            syn_valid = !((k >= 141) && (k < 150));
            syn_zero  = (k >= 200);
        end
        chk("early_done_cycle", 32'(done_cyc), 32'd292);
        chk("early_iter", 32'(iter_done), 32'd1);
        chk("early_success", 32'(succ_done), 32'd1);
        chk("early_wr_pulses", 32'(n_wr), 32'd8);

        // ---------------- RD_LAT = 3 ----------------
        do_reset();
        start = 1'b1; syn_valid = 1'b0; syn_zero = 1'b0;
        n_rd = 0; n_ld = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (c_rd) begin
                if (n_rd < 4) rd_cyc[n_rd] = k;
                n_rd++;
            end
            if (c_ld) begin
                if (n_ld < 4) ld_cyc[n_ld] = k;
                n_ld++;
            end
            if (k == 6) chk("rdlat_cmin_first", {27'd0, c_min, c_cmin}, 32'h20);
        end
        chk("rdlat_rd_count", 32'(n_rd), 32'd2);
        chk("rdlat_rd_0", 32'(rd_cyc[0]), 32'd1);
        chk("rdlat_ld_0", 32'(ld_cyc[0]), 32'd4);
        chk("rdlat_rd_1", 32'(rd_cyc[1]), 32'd38);

        chk("onehot_strobes", 32'(onehot_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cnu_layer_sequencer
`default_nettype wire
